// File: rtl/traffic_phase_ctrl_if.sv
// Status/control bundle between traffic_phase_ctrl and its consumers (VGA display, status logic).
// The master side is the controller; the slave side supplies traffic_sel and observes the lights.
interface traffic_phase_ctrl_if #(
   parameter int NUM_PHASES = 2,
   parameter int CNT_W      = 6
);
   localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   logic [1:0]       traffic_sel;
   logic [PH_W-1:0]  o_phase;
   logic [1:0]       o_light;
   logic [CNT_W-1:0] o_remain;
   logic [1:0]       o_tr_state;
   logic             tr_valid;
   logic             light_valid;

   modport master (
      input  traffic_sel,
      output o_phase,
      output o_light,
      output o_remain,
      output o_tr_state,
      output tr_valid,
      output light_valid
   );

   modport slave (
      output traffic_sel,
      input  o_phase,
      input  o_light,
      input  o_remain,
      input  o_tr_state,
      input  tr_valid,
      input  light_valid
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal FSM with a built-in 1 s tick divider: CLR -> GREEN (-> YELLOW) -> CLR.
// Define SIGNAL_YELLOW_EN to include the YELLOW state; without it GREEN goes straight to all-red.
module traffic_phase_ctrl #(
   parameter int CLK_HZ      = 100_000_000,
   parameter int NUM_PHASES  = 2,
   parameter int CNT_W       = 6,
   parameter int MAIN_G0     = 20,
   parameter int MAIN_G1     = 10,
   parameter int MAIN_G2     = 30,
   parameter int SIDE_G0     = 20,
   parameter int SIDE_G1     = 30,
   parameter int SIDE_G2     = 10,
   parameter int YELLOW_SEC  = 3,
   parameter int RED_CLR_SEC = 2
) (
   input  logic clk,
   input  logic reset,
   traffic_phase_ctrl_if.master bus
);

   localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NUM_PHASES - 1);

   localparam int DUR_MAX = (2 ** CNT_W) - 1;

   if (NUM_PHASES < 2 || NUM_PHASES > 4 ||
       MAIN_G0 > DUR_MAX || MAIN_G1 > DUR_MAX || MAIN_G2 > DUR_MAX ||
       SIDE_G0 > DUR_MAX || SIDE_G1 > DUR_MAX || SIDE_G2 > DUR_MAX ||
       YELLOW_SEC > DUR_MAX || RED_CLR_SEC > DUR_MAX ||
       MAIN_G0 < 0 || MAIN_G1 < 0 || MAIN_G2 < 0 ||
       SIDE_G0 < 0 || SIDE_G1 < 0 || SIDE_G2 < 0 ||
       YELLOW_SEC < 0 || RED_CLR_SEC < 0) begin : g_bad_param
      $error("traffic_phase_ctrl: NUM_PHASES out of 2..4 or a duration does not fit CNT_W");
   end

   // A zero duration would never see remain==1, so it is promoted to one tick.
   function automatic logic [CNT_W-1:0] dur(input int sec);
      return (sec == 0) ? CNT_W'(1) : CNT_W'(sec);
   endfunction

   localparam logic [CNT_W-1:0] D_CLR = dur(RED_CLR_SEC);
   localparam logic [CNT_W-1:0] D_MG0 = dur(MAIN_G0);
   localparam logic [CNT_W-1:0] D_MG1 = dur(MAIN_G1);
   localparam logic [CNT_W-1:0] D_MG2 = dur(MAIN_G2);
   localparam logic [CNT_W-1:0] D_SG0 = dur(SIDE_G0);
   localparam logic [CNT_W-1:0] D_SG1 = dur(SIDE_G1);
   localparam logic [CNT_W-1:0] D_SG2 = dur(SIDE_G2);

   localparam logic [1:0] L_RED = 2'b00;
   localparam logic [1:0] L_GRN = 2'b01;
`ifdef SIGNAL_YELLOW_EN
   localparam logic [1:0]       L_YEL = 2'b10;
   localparam logic [CNT_W-1:0] D_YEL = dur(YELLOW_SEC);

   typedef enum logic [1:0] {S_CLR, S_GREEN, S_YELLOW} state_t;
`else
   typedef enum logic [1:0] {S_CLR, S_GREEN} state_t;
`endif

   state_t           state_q;
   logic [DIV_W-1:0] div_q;
   logic [PH_W-1:0]  phase_q;
   logic [1:0]       light_q;
   logic [CNT_W-1:0] remain_q;
   logic [1:0]       tr_q;
   logic             trv_q;
   logic             lv_q;
   logic             first_q;

   logic             tick;
   logic [1:0]       lvl_in;
   logic [PH_W-1:0]  phase_d;
   logic [1:0]       lvl_d;
   logic [CNT_W-1:0] green_d;

   assign tick = (div_q == DIV_MAX);

   // Next-green selection: only an entry into phase 0 takes a fresh level.
   always_comb begin
      lvl_in  = (bus.traffic_sel == 2'd3) ? 2'd2 : bus.traffic_sel;
      phase_d = '0;
      if (!first_q && phase_q != PH_LAST) begin
         phase_d = phase_q + PH_W'(1);
      end
      lvl_d   = (phase_d == '0) ? lvl_in : tr_q;
      green_d = D_MG2;
      unique case (lvl_d)
         2'd0:    green_d = (phase_d == '0) ? D_MG0 : D_SG0;
         2'd1:    green_d = (phase_d == '0) ? D_MG1 : D_SG1;
         default: green_d = (phase_d == '0) ? D_MG2 : D_SG2;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q    <= '0;
         state_q  <= S_CLR;
         phase_q  <= '0;
         light_q  <= L_RED;
         remain_q <= D_CLR;
         tr_q     <= '0;
         trv_q    <= 1'b0;
         lv_q     <= 1'b0;
         first_q  <= 1'b1;
      end else begin
         trv_q <= 1'b0;
         lv_q  <= 1'b0;
         div_q <= tick ? '0 : div_q + DIV_W'(1);
         if (tick) begin
            if (remain_q > CNT_W'(1)) begin
               remain_q <= remain_q - CNT_W'(1);
            end else begin
               lv_q <= 1'b1;
               unique case (state_q)
                  S_CLR: begin
                     state_q  <= S_GREEN;
                     light_q  <= L_GRN;
                     phase_q  <= phase_d;
                     remain_q <= green_d;
                     first_q  <= 1'b0;
                     if (phase_d == '0) begin
                        tr_q  <= lvl_d;
                        trv_q <= (lvl_d != tr_q);
                     end
                  end
`ifdef SIGNAL_YELLOW_EN
                  S_GREEN: begin
                     state_q  <= S_YELLOW;
                     light_q  <= L_YEL;
                     remain_q <= D_YEL;
                  end
                  S_YELLOW: begin
                     state_q  <= S_CLR;
                     light_q  <= L_RED;
                     remain_q <= D_CLR;
                  end
`else
                  S_GREEN: begin
                     state_q  <= S_CLR;
                     light_q  <= L_RED;
                     remain_q <= D_CLR;
                  end
`endif
                  default: begin
                     state_q  <= S_CLR;
                     light_q  <= L_RED;
                     remain_q <= D_CLR;
                  end
               endcase
            end
         end
      end
   end

   assign bus.o_phase     = phase_q;
   assign bus.o_light     = light_q;
   assign bus.o_remain    = remain_q;
   assign bus.o_tr_state  = tr_q;
   assign bus.tr_valid    = trv_q;
   assign bus.light_valid = lv_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: every expected light change is queued when its
// round of traffic_sel stimulus is planned, and popped when the DUT raises light_valid.
module tb_traffic_phase_ctrl;
   localparam int CLK_HZ = 10;
   localparam int NPH    = 2;
   localparam int CNT_W  = 6;
   localparam int CLR_T  = 2;
   localparam int YEL_T  = 3;

   typedef struct {
      int edge_n;
      int ph;
      int lt;
      int rem;
      int trs;
      int trv;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   ecnt = 0;
   int   vectors = 0;
   int   miscompares = 0;
   ev_t  exp_q[$];
   ev_t  ev;
   int   t_now;
   int   prev_lvl;

   traffic_phase_ctrl_if #(.NUM_PHASES(NPH), .CNT_W(CNT_W)) bus ();

   traffic_phase_ctrl #(
      .CLK_HZ     (CLK_HZ),
      .NUM_PHASES (NPH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (reset) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      vectors++;
      if (got !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, expv, ecnt);
      end
   endtask

   function automatic int main_g(input int l);
      case (l)
         0:       return 20;
         1:       return 10;
         default: return 30;
      endcase
   endfunction

   function automatic int side_g(input int l);
      case (l)
         0:       return 20;
         1:       return 30;
         default: return 10;
      endcase
   endfunction

   task automatic push(input int tk, input int ph, input int lt, input int rem,
                       input int trs, input int trv);
      ev_t e;
      e.edge_n = tk * CLK_HZ;
      e.ph = ph; e.lt = lt; e.rem = rem; e.trs = trs; e.trv = trv;
      exp_q.push_back(e);
   endtask

   task automatic wait_edge(input int n);
      while (ecnt < n) @(negedge clk);
   endtask

   task automatic check_reset();
      check("rst_phase",  32'(bus.o_phase),     0);
      check("rst_light",  32'(bus.o_light),     0);
      check("rst_remain", 32'(bus.o_remain),    CLR_T);
      check("rst_tr",     32'(bus.o_tr_state),  0);
      check("rst_trv",    32'(bus.tr_valid),    0);
      check("rst_lv",     32'(bus.light_valid), 0);
   endtask

   // Plans one full rotation starting at the phase-0 green entry at tick t_now.
   task automatic run_round(input int sel, input bit toggle);
      int lvl;
      int start;
      start = t_now;
      wait_edge(start * CLK_HZ - 5);
      bus.traffic_sel = 2'(sel);
      lvl = (sel == 3) ? 2 : sel;
      for (int p = 0; p < NPH; p++) begin
         push(t_now, p, 1, (p == 0) ? main_g(lvl) : side_g(lvl), lvl,
              (p == 0 && lvl != prev_lvl) ? 1 : 0);
         t_now += (p == 0) ? main_g(lvl) : side_g(lvl);
`ifdef SIGNAL_YELLOW_EN
         push(t_now, p, 2, YEL_T, lvl, 0);
         t_now += YEL_T;
`endif
         push(t_now, p, 0, CLR_T, lvl, 0);
         t_now += CLR_T;
      end
      prev_lvl = lvl;
      if (toggle) begin
         for (int k = 0; k < 4; k++) begin
            wait_edge(start * CLK_HZ + 20 + 20 * k);
            bus.traffic_sel = (k % 2 == 0) ? 2'd0 : 2'd1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.light_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_light_valid", 1, 0);
            end else begin
               ev = exp_q.pop_front();
               check("change_edge", ecnt, ev.edge_n);
               check("phase",       32'(bus.o_phase),    ev.ph);
               check("light",       32'(bus.o_light),    ev.lt);
               check("remain",      32'(bus.o_remain),   ev.rem);
               check("tr_state",    32'(bus.o_tr_state), ev.trs);
               check("tr_valid",    32'(bus.tr_valid),   ev.trv);
            end
         end else begin
            if (bus.tr_valid) check("tr_valid_alone", 1, 0);
            if (exp_q.size() > 0 && ecnt > exp_q[0].edge_n) begin
               check("missed_change", ecnt, exp_q[0].edge_n);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: got edge %0d expected completion", ecnt);
      $fatal(1, "simulation timeout");
   end

   initial begin
      int t_mid;
      reset = 1'b1;
      bus.traffic_sel = 2'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset();
      reset = 1'b0;
      t_now = CLR_T;
      prev_lvl = 0;

      run_round(0, 1'b0);
      run_round(2, 1'b0);
      run_round(3, 1'b0);
      run_round(1, 1'b1);
      run_round(0, 1'b0);

      // Reset lands 12 cycles into phase-0 yellow (all-red when yellow is not built).
      t_mid = t_now + main_g(0);
      run_round(0, 1'b0);
      wait_edge(t_mid * CLK_HZ + 12);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset();
      reset = 1'b0;
      t_now = CLR_T;
      prev_lvl = 0;

      run_round(2, 1'b0);
      wait_edge(t_now * CLK_HZ - 3);
      check("queue_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
